// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    // LSB position of a port's field inside a packed multi-port vector.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_busy_table.sv
// Per-register busy scoreboard with a live count of pending writes and
// per-read-port busy lookups that are unblocked by a same-cycle writeback.
module reg_busy_table
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        write_add,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_add,
    input  logic [NUM_RD*ADDR_W-1:0] read_add,
    output logic [NUM_RD-1:0]        read_busy,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  cnt_reg;
    logic [ADDR_W:0]  cnt_next;
    logic             rsv_ok;
    logic             cnt_inc;
    logic             cnt_dec;

    always_comb begin
        rsv_ok    = rsv_en && !((ZERO_REG != 0) && (rsv_add == ADDR_W'(ZERO_ADDR)));
        // Clear first, then set: a reservation beats a writeback to the same register.
        busy_next = busy_reg;
        if (write_en)
            busy_next[write_add] = 1'b0;
        if (rsv_ok)
            busy_next[rsv_add] = 1'b1;

        cnt_inc  = rsv_ok && !busy_reg[rsv_add];
        cnt_dec  = write_en && busy_reg[write_add] && !(rsv_ok && (rsv_add == write_add));
        cnt_next = cnt_reg;
        if (cnt_inc && !cnt_dec)
            cnt_next = cnt_reg + CNT_ONE;
        else if (cnt_dec && !cnt_inc)
            cnt_next = cnt_reg - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (cnt_reg == (ADDR_W+1)'($countones(busy_reg)));
    end

    assign busy_cnt = cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_busy_rd
            logic [ADDR_W-1:0] ra;
            assign ra = read_add[port_lsb(gi, ADDR_W) +: ADDR_W];
            assign read_busy[gi] = busy_reg[ra] && !(write_en && (write_add == ra));
        end
    endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with zero register, write-first bypass and a
// busy scoreboard used by decode to stall on pending producers.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_add,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        write_add,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_add,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              wr_ok;

    assign wr_ok = write_en && !((ZERO_REG != 0) && (write_add == ADDR_W'(ZERO_ADDR)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (wr_ok) begin
            mem_reg[write_add] <= write_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            assign ra = read_add[port_lsb(gi, ADDR_W) +: ADDR_W];
            always_comb begin
                rd = mem_reg[ra];
                if (rst)
                    rd = '0;
                else if ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR)))
                    rd = '0;
                else if (write_en && (write_add == ra))
                    rd = write_data;
            end
            assign read_data[port_lsb(gi, DATA_W) +: DATA_W] = rd;
        end
    endgenerate

    reg_busy_table #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .write_add (write_add),
        .rsv_en    (rsv_en),
        .rsv_add   (rsv_add),
        .read_add  (read_add),
        .read_busy (read_busy),
        .busy_cnt  (busy_cnt)
    );

endmodule
